// File: rtl/seq_pkg.sv
// Shared encodings for the LED shift sequencer: FSM states, pattern modes and shift direction.
package seq_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_DWELL = 2'd3;

  localparam logic [1:0] MODE_LEFT   = 2'd0;
  localparam logic [1:0] MODE_RIGHT  = 2'd1;
  localparam logic [1:0] MODE_BOUNCE = 2'd2;
  localparam logic [1:0] MODE_RSVD   = 2'd3;

  localparam logic DIR_LEFT  = 1'b1;
  localparam logic DIR_RIGHT = 1'b0;

  // Initial shift direction of a pattern; bounce starts moving toward the MSB.
  function automatic logic mode_dir(input logic [1:0] m);
    return (m == MODE_RIGHT) ? DIR_RIGHT : DIR_LEFT;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: one-cycle tick every DIV clocks; clr holds the count at zero.
module tick_gen #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick_c
);

  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

  logic [PW-1:0] pcnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcnt <= '0;
    end else if (clr || (pcnt == PMAX)) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + PW'(1);
    end
  end

  assign tick_c = !clr && (pcnt == PMAX);

endmodule

// File: rtl/shift_sequencer.sv
// Sequencer for the LED shift register: load/shift/direction strobes paced by a prescaled tick.
// Build macro SEQ_LOSS_DETECT_EN adds the err output and one-hot recovery of the q feedback.
module shift_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIV   = 4,
  parameter int unsigned DWELL = 2,
  parameter int unsigned NPASS = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] q,
  output logic             sh_load,
  output logic [WIDTH-1:0] sh_seed,
  output logic             sh_en,
  output logic             sh_dir,
  output logic             busy,
  output logic             done,
`ifdef SEQ_LOSS_DETECT_EN
  output logic             err,
`endif
  output logic [7:0]       pass_cnt
);

  localparam int unsigned DCW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DCW-1:0] DLAST = DCW'((DWELL > 0) ? (DWELL - 1) : 0);

  logic [1:0]       state, state_n;
  logic [1:0]       mode_q, mode_n;
  logic [DCW-1:0]   dcnt, dcnt_n;
  logic             dir_n, load_n, en_n, done_n;
  logic [WIDTH-1:0] seed_n;
  logic [7:0]       pass_n, pass_inc;
  logic             tick, tick_clr, at_end, complete;
`ifdef SEQ_LOSS_DETECT_EN
  logic             err_n, lost;
`else
  logic             unused_q;
  assign unused_q = ^q;
`endif

  // Single lit bit at the pattern's starting end.
  function automatic logic [WIDTH-1:0] seed_of(input logic [1:0] m);
    return (m == MODE_RIGHT) ? {1'b1, {(WIDTH-1){1'b0}}} : {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  assign tick_clr = (state == ST_IDLE) || (state == ST_LOAD);

  tick_gen #(.DIV(DIV)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .clr    (tick_clr),
    .tick_c (tick)
  );

  assign at_end   = (sh_dir == DIR_LEFT) ? q[WIDTH-1] : q[0];
  assign pass_inc = (pass_cnt == 8'hFF) ? 8'hFF : pass_cnt + 8'd1;
  assign complete = (NPASS != 0) && (32'(pass_inc) == NPASS);
`ifdef SEQ_LOSS_DETECT_EN
  assign lost     = (q == '0) || ((q & (q - {{(WIDTH-1){1'b0}}, 1'b1})) != '0);
`endif

  always_comb begin
    state_n = state;
    mode_n  = mode_q;
    dir_n   = sh_dir;
    pass_n  = pass_cnt;
    dcnt_n  = dcnt;
    load_n  = 1'b0;
    seed_n  = '0;
    en_n    = 1'b0;
    done_n  = 1'b0;
`ifdef SEQ_LOSS_DETECT_EN
    err_n   = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (start && !stop && (mode != MODE_RSVD)) begin
          state_n = ST_LOAD;
          mode_n  = mode;
          dir_n   = mode_dir(mode);
          pass_n  = '0;
          load_n  = 1'b1;
          seed_n  = seed_of(mode);
        end
      end
      ST_LOAD: state_n = ST_SHIFT;
      ST_SHIFT: begin
        if (tick) begin
          if (!at_end) begin
            en_n = 1'b1;
          end else if (complete) begin
            state_n = ST_IDLE;
            pass_n  = pass_inc;
            done_n  = 1'b1;
          end else begin
            pass_n = pass_inc;
            if (mode_q == MODE_BOUNCE) begin
              dir_n = !sh_dir;
              if (DWELL != 0) state_n = ST_DWELL;
            end else begin
              load_n = 1'b1;
              seed_n = seed_of(mode_q);
            end
          end
        end
      end
      ST_DWELL: begin
        if (tick) begin
          if (dcnt == DLAST) begin
            dcnt_n  = '0;
            state_n = ST_SHIFT;
          end else begin
            dcnt_n = dcnt + DCW'(1);
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
`ifdef SEQ_LOSS_DETECT_EN
    // A lost or duplicated bit restarts the pattern instead of being shifted along
    if (tick && lost && ((state == ST_SHIFT) || (state == ST_DWELL))) begin
      state_n = ST_SHIFT;
      dcnt_n  = '0;
      dir_n   = mode_dir(mode_q);
      pass_n  = pass_cnt;
      load_n  = 1'b1;
      seed_n  = seed_of(mode_q);
      en_n    = 1'b0;
      done_n  = 1'b0;
      err_n   = 1'b1;
    end
`endif
    // Abort keeps direction and pass count for inspection until the next start
    if (stop && (state != ST_IDLE)) begin
      state_n = ST_IDLE;
      dir_n   = sh_dir;
      pass_n  = pass_cnt;
      dcnt_n  = '0;
      load_n  = 1'b0;
      seed_n  = '0;
      en_n    = 1'b0;
      done_n  = 1'b0;
`ifdef SEQ_LOSS_DETECT_EN
      err_n   = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q   <= MODE_LEFT;
      dcnt     <= '0;
      sh_load  <= 1'b0;
      sh_seed  <= '0;
      sh_en    <= 1'b0;
      sh_dir   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass_cnt <= '0;
`ifdef SEQ_LOSS_DETECT_EN
      err      <= 1'b0;
`endif
    end else begin
      mode_q   <= mode_n;
      dcnt     <= dcnt_n;
      sh_load  <= load_n;
      sh_seed  <= seed_n;
      sh_en    <= en_n;
      sh_dir   <= dir_n;
      busy     <= (state_n != ST_IDLE);
      done     <= done_n;
      pass_cnt <= pass_n;
`ifdef SEQ_LOSS_DETECT_EN
      err      <= err_n;
`endif
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: a dwell/auto-stop instance and a no-dwell free-running instance share
// stimulus and are compared every cycle against a tick-level pattern model.
module tb_shift_sequencer;

  localparam int unsigned W   = 8;
  localparam int unsigned DIV = 4;

  logic         clk = 1'b0;
  logic         reset, start, stop;
  logic [1:0]   mode;
  logic [W-1:0] q_a, q_b;
  logic         zap_a, zap_b;

  logic         a_load, a_en, a_dir, a_busy, a_done, a_err;
  logic         b_load, b_en, b_dir, b_busy, b_done, b_err;
  logic [W-1:0] a_seed, b_seed;
  logic [7:0]   a_pass, b_pass;
  logic [21:0]  obs_a, obs_b;

  always #5 clk = ~clk;

  shift_sequencer #(.WIDTH(W), .DIV(DIV), .DWELL(2), .NPASS(2)) u_a (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .mode(mode), .q(q_a),
    .sh_load(a_load), .sh_seed(a_seed), .sh_en(a_en), .sh_dir(a_dir),
    .busy(a_busy), .done(a_done),
`ifdef SEQ_LOSS_DETECT_EN
    .err(a_err),
`endif
    .pass_cnt(a_pass)
  );

  shift_sequencer #(.WIDTH(W), .DIV(DIV), .DWELL(0), .NPASS(0)) u_b (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .mode(mode), .q(q_b),
    .sh_load(b_load), .sh_seed(b_seed), .sh_en(b_en), .sh_dir(b_dir),
    .busy(b_busy), .done(b_done),
`ifdef SEQ_LOSS_DETECT_EN
    .err(b_err),
`endif
    .pass_cnt(b_pass)
  );

`ifndef SEQ_LOSS_DETECT_EN
  assign a_err = 1'b0;
  assign b_err = 1'b0;
`endif

  assign obs_a = {a_err, a_busy, a_load, a_en, a_done, a_dir, a_pass, (a_load ? a_seed : 8'h00)};
  assign obs_b = {b_err, b_busy, b_load, b_en, b_done, b_dir, b_pass, (b_load ? b_seed : 8'h00)};

  // Shift register models driven by the strobes; zap forces a corrupted (empty) register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      q_a <= '0;
    else if (zap_a)  q_a <= '0;
    else if (a_load) q_a <= a_seed;
    else if (a_en)   q_a <= a_dir ? {q_a[W-2:0], 1'b0} : {1'b0, q_a[W-1:1]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      q_b <= '0;
    else if (zap_b)  q_b <= '0;
    else if (b_load) q_b <= b_seed;
    else if (b_en)   q_b <= b_dir ? {q_b[W-2:0], 1'b0} : {1'b0, q_b[W-1:1]};
  end

  // Reference model: lit-bit position, direction, passes and dwell ticks left, per instance
  int         r_dw [2];
  int         r_np [2];
  bit         r_busy [2], r_dir [2], corrupt [2];
  bit         e_load [2], e_en [2], e_done [2], e_err [2];
  logic [1:0] r_mode [2];
  logic [7:0] r_pass [2], e_seed [2];
  int         r_pos [2], r_cyc [2], r_dwell [2];

  int    n_tests = 0;
  int    n_fail  = 0;
  string phase   = "init";

  function automatic logic [7:0] seed_at(input int pos);
    logic [7:0] v;
    v = 8'h01;
    return v << pos;
  endfunction

  task automatic ref_reset();
    for (int i = 0; i < 2; i++) begin
      r_busy[i] = 0; r_dir[i] = 0; corrupt[i] = 0;
      e_load[i] = 0; e_en[i] = 0; e_done[i] = 0; e_err[i] = 0;
      r_mode[i] = 2'd0; r_pass[i] = 8'd0; e_seed[i] = 8'd0;
      r_pos[i] = 0; r_cyc[i] = 0; r_dwell[i] = 0;
    end
  endtask

  // Advance one clock. Cycle 0 is the load cycle; ticks fall on cycles DIV, 2*DIV, ... and
  // their effect is visible on the following cycle.
  task automatic ref_next(input int i);
    int  c_prev;
    bit  at_end;
    e_load[i] = 0; e_en[i] = 0; e_done[i] = 0; e_err[i] = 0; e_seed[i] = 8'd0;
    if (!r_busy[i]) begin
      if (start && !stop && (mode != 2'd3)) begin
        r_busy[i]  = 1;
        r_mode[i]  = mode;
        r_dir[i]   = (mode != 2'd1);
        r_pos[i]   = (mode == 2'd1) ? 7 : 0;
        r_pass[i]  = 8'd0;
        r_cyc[i]   = 0;
        r_dwell[i] = 0;
        corrupt[i] = 0;
        e_load[i]  = 1;
        e_seed[i]  = seed_at(r_pos[i]);
      end
    end else if (stop) begin
      r_busy[i] = 0;
    end else begin
      c_prev   = r_cyc[i];
      r_cyc[i] = r_cyc[i] + 1;
      if ((c_prev > 0) && ((c_prev % DIV) == 0)) begin
        at_end = (r_dir[i] && r_pos[i] == 7) || (!r_dir[i] && r_pos[i] == 0);
        if (corrupt[i]) begin
          corrupt[i] = 0;
          r_dir[i]   = (r_mode[i] != 2'd1);
          r_pos[i]   = (r_mode[i] == 2'd1) ? 7 : 0;
          r_dwell[i] = 0;
          e_load[i]  = 1;
          e_seed[i]  = seed_at(r_pos[i]);
          e_err[i]   = 1;
        end else if (r_dwell[i] > 0) begin
          r_dwell[i] = r_dwell[i] - 1;
        end else if (at_end) begin
          if (r_pass[i] != 8'hFF) r_pass[i] = r_pass[i] + 8'd1;
          if ((r_np[i] != 0) && (int'(r_pass[i]) == r_np[i])) begin
            e_done[i] = 1;
            r_busy[i] = 0;
          end else if (r_mode[i] == 2'd2) begin
            r_dir[i]   = !r_dir[i];
            r_dwell[i] = r_dw[i];
          end else begin
            r_pos[i]  = (r_mode[i] == 2'd1) ? 7 : 0;
            e_load[i] = 1;
            e_seed[i] = seed_at(r_pos[i]);
          end
        end else begin
          e_en[i]  = 1;
          r_pos[i] = r_dir[i] ? r_pos[i] + 1 : r_pos[i] - 1;
        end
      end
    end
  endtask

  task automatic check_all();
    logic [21:0] exp_v, obs_v;
    for (int i = 0; i < 2; i++) begin
      exp_v = {e_err[i], r_busy[i], e_load[i], e_en[i], e_done[i], r_dir[i], r_pass[i], e_seed[i]};
      obs_v = (i == 0) ? obs_a : obs_b;
      n_tests++;
      assert (obs_v === exp_v) else begin
        n_fail++;
        $error("FAIL %s inst%0d {err,busy,load,en,done,dir,pass,seed} got=%h want=%h", phase, i, obs_v, exp_v);
      end
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s got=%0d want=%0d", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    ref_next(0);
    ref_next(1);
    #1;
    check_all();
  endtask

  initial begin
    int found, cnt, n;
    reset = 1'b0; start = 1'b0; stop = 1'b0; mode = 2'd0; zap_a = 1'b0; zap_b = 1'b0;
    r_dw = '{2, 0};
    r_np = '{2, 0};
    ref_reset();

    phase = "reset";
    repeat (3) @(posedge clk);
    #1 check_all();
    reset = 1'b1;
    repeat (4) cycle();

    phase = "mode3";
    mode = 2'd3; start = 1'b1;
    cnt = 0;
    repeat (12) begin cycle(); if (a_load || b_load) cnt++; end
    start = 1'b0; mode = 2'd0;
    chk_int("mode3_no_load", cnt, 0);

    phase = "left";
    start = 1'b1; cycle(); start = 1'b0;
    repeat (90) cycle();

    phase = "midreset";
    reset = 1'b0;
    #1;
    ref_reset();
    check_all();
    @(posedge clk);
    #1 check_all();
    reset = 1'b1;
    repeat (2) cycle();

    phase = "bounce";
    mode = 2'd2; start = 1'b1; cycle(); start = 1'b0; mode = 2'd1;
    cnt = 0;
    repeat (100) begin cycle(); if (a_done) cnt++; end
    chk_int("bounce_done_once", cnt, 1);
    stop = 1'b1; cycle(); stop = 1'b0; cycle();

    phase = "right_stop";
    mode = 2'd1; start = 1'b1; cycle(); start = 1'b0;
    found = 0;
    for (int k = 0; k < 100 && found == 0; k++) begin
      cycle();
      if (q_a == 8'h10) found = 1;
    end
    chk_int("right_reach_0x10", found, 1);
    stop = 1'b1; repeat (6) cycle(); stop = 1'b0;
    repeat (10) cycle();
    chk_int("right_hold_a", int'(q_a), 'h10);
    chk_int("right_hold_b", int'(q_b), 'h10);

    phase = "start_stop";
    mode = 2'd0; start = 1'b1; stop = 1'b1;
    repeat (6) cycle();
    start = 1'b0; stop = 1'b0;
    repeat (2) cycle();

`ifdef SEQ_LOSS_DETECT_EN
    phase = "loss";
    mode = 2'd0; start = 1'b1; cycle(); start = 1'b0;
    found = 0;
    for (int k = 0; k < 100 && found == 0; k++) begin
      cycle();
      if (q_b == 8'h04) found = 1;
    end
    chk_int("loss_reach_0x04", found, 1);
    zap_b = 1'b1; corrupt[1] = 1; cycle(); zap_b = 1'b0;
    cnt = 0;
    repeat (12) begin cycle(); if (b_err) cnt++; end
    chk_int("loss_err_once", cnt, 1);
    chk_int("loss_pass_kept", int'(b_pass), 0);
    stop = 1'b1; cycle(); stop = 1'b0; cycle();
`endif

    phase = "random";
    for (int it = 0; it < 24; it++) begin
      mode  = 2'($urandom_range(0, 3));
      start = 1'b1;
      stop  = ($urandom_range(0, 7) == 0);
      cycle();
      start = 1'b0; stop = 1'b0;
      n = $urandom_range(10, 160);
      repeat (n) begin
        if ($urandom_range(0, 9) == 0) mode = 2'($urandom_range(0, 3));
        start = ($urandom_range(0, 19) == 0);
        cycle();
      end
      start = 1'b0;
      stop  = 1'b1; cycle(); stop = 1'b0;
      repeat ($urandom_range(1, 4)) cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
